// File: rtl/exc_seq_ctrl_if.sv
// Bundle between the M stage / cp0 / fetch and the exception sequencer.
// The slave modport is the sequencer's view; master is the surrounding pipeline.
interface exc_seq_ctrl_if #(
    parameter int unsigned CNT_W = 8
);
    logic [5:0]       irq_in;
    logic             m_valid;
    logic [4:0]       m_exc;
    logic [31:0]      m_pc;
    logic             m_bds;
    logic             m_eret;
    logic             cp0_have2handle;
    logic [31:0]      cp0_epc;
    logic [5:0]       cp0_hwirq;
    logic [4:0]       cp0_exc;
    logic [31:0]      cp0_curr_pc;
    logic             cp0_in_bds;
    logic             cp0_exit_isr;
    logic             flush;
    logic             redirect_valid;
    logic [31:0]      redirect_pc;
    logic             redirect_ready;
    logic [CNT_W-1:0] exc_dropped;

    modport slave (
        input  irq_in, m_valid, m_exc, m_pc, m_bds, m_eret,
               cp0_have2handle, cp0_epc, redirect_ready,
        output cp0_hwirq, cp0_exc, cp0_curr_pc, cp0_in_bds, cp0_exit_isr,
               flush, redirect_valid, redirect_pc, exc_dropped
    );

    modport master (
        output irq_in, m_valid, m_exc, m_pc, m_bds, m_eret,
               cp0_have2handle, cp0_epc, redirect_ready,
        input  cp0_hwirq, cp0_exc, cp0_curr_pc, cp0_in_bds, cp0_exit_isr,
               flush, redirect_valid, redirect_pc, exc_dropped
    );
endinterface

// File: rtl/exc_seq_ctrl.sv
// Exception/interrupt sequencer: synchronizes IRQs into cp0, turns a taken
// exception or eret into a flush plus a held fetch redirect, counts dropped exceptions.
module exc_seq_ctrl #(
    parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180,
    parameter logic [4:0]  EXC_NONE     = 5'd31,
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned CNT_W        = 8
) (
    input  logic          clk,
    input  logic          rst,
    exc_seq_ctrl_if.slave bus
);
    typedef enum logic {RUN, REDIRECT} state_t;

    state_t           state_q, state_d;
    logic             redirect_valid_q, redirect_valid_d;
    logic [31:0]      redirect_pc_q, redirect_pc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [5:0]       sync_q [SYNC_STAGES];
    logic [5:0]       irq_s;

    logic live, take, ret, drop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= bus.irq_in;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign irq_s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= RUN;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            cnt_q            <= '0;
        end else begin
            state_q          <= state_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            cnt_q            <= cnt_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        redirect_valid_d = redirect_valid_q;
        redirect_pc_d    = redirect_pc_q;
        cnt_d            = cnt_q;
        live             = 1'b0;
        take             = 1'b0;
        ret              = 1'b0;
        drop             = 1'b0;
        unique case (state_q)
            RUN: begin
                live = bus.m_valid;
                take = bus.cp0_have2handle;
                ret  = bus.m_valid && bus.m_eret && !take;
                // cp0 with EXL=1 presents the exception but does not raise have2handle
                drop = bus.m_valid && (bus.m_exc != EXC_NONE) && !take;
                if (take) begin
                    state_d          = REDIRECT;
                    redirect_valid_d = 1'b1;
                    redirect_pc_d    = HANDLER_ADDR;
                end else if (ret) begin
                    state_d          = REDIRECT;
                    redirect_valid_d = 1'b1;
                    redirect_pc_d    = bus.cp0_epc;
                end
                if (drop && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
            end
            REDIRECT: begin
                if (bus.redirect_ready) begin
                    state_d          = RUN;
                    redirect_valid_d = 1'b0;
                end
            end
            default: state_d = RUN;
        endcase
    end

    assign bus.cp0_hwirq      = live ? irq_s : 6'b0;
    assign bus.cp0_exc        = live ? bus.m_exc : EXC_NONE;
    assign bus.cp0_curr_pc    = bus.m_pc;
    assign bus.cp0_in_bds     = bus.m_bds;
    assign bus.cp0_exit_isr   = ret;
    assign bus.flush          = take | ret;
    assign bus.redirect_valid = redirect_valid_q;
    assign bus.redirect_pc    = redirect_pc_q;
    assign bus.exc_dropped    = cnt_q;
endmodule
